// File: rtl/xadac_pkg.sv
// xadac_pkg: shared xadac channel types.
// SbLen sets the scoreboard depth, and so the width of every instruction id.
package xadac_pkg;
  localparam int SbLen = 8;
  localparam int SbIdW = $clog2(SbLen);

  typedef struct packed {
    logic [SbIdW-1:0] id;
    logic [31:0]      instr;
  } DecReqT;

  typedef struct packed {
    logic [SbIdW-1:0] id;
    logic             accept;
    logic [4:0]       rd;
  } DecRspT;

  typedef struct packed {
    logic [SbIdW-1:0] id;
    logic [31:0]      rs1;
  } ExeReqT;

  typedef struct packed {
    logic [SbIdW-1:0] id;
    logic [31:0]      rd_data;
  } ExeRspT;
endpackage

// File: rtl/xadac_if.sv
// xadac_if: issuer <-> accelerator bundle.
// Four channels: dec req/rsp and exe req/rsp, each with a valid/ready handshake.
// mst: the issuing side. slv: the accepting side.
interface xadac_if;
  import xadac_pkg::*;

  DecReqT dec_req;
  logic   dec_req_valid;
  logic   dec_req_ready;
  DecRspT dec_rsp;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;
  ExeReqT exe_req;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeRspT exe_rsp;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;

  modport mst (
    output dec_req, dec_req_valid, input  dec_req_ready,
    input  dec_rsp, dec_rsp_valid, output dec_rsp_ready,
    output exe_req, exe_req_valid, input  exe_req_ready,
    input  exe_rsp, exe_rsp_valid, output exe_rsp_ready
  );

  modport slv (
    input  dec_req, dec_req_valid, output dec_req_ready,
    output dec_rsp, dec_rsp_valid, input  dec_rsp_ready,
    input  exe_req, exe_req_valid, output exe_req_ready,
    output exe_rsp, exe_rsp_valid, input  exe_rsp_ready
  );
endinterface

// File: rtl/xadac_rr_arb.sv
// xadac_rr_arb: NoSlv-way round-robin arbiter with grant lock.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   valid      per-requester request lines
//   ready      downstream ready for the current grant
//   gnt_idx    index of the granted requester
//   gnt_valid  a grant is being offered this cycle
// A grant that is offered but not accepted is locked until its handshake.
module xadac_rr_arb #(
  parameter int NoSlv = 2
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic [NoSlv-1:0]                          valid,
  input  logic                                      ready,
  output logic [((NoSlv > 1) ? $clog2(NoSlv) : 1)-1:0] gnt_idx,
  output logic                                      gnt_valid
);
  localparam int IdxW = (NoSlv > 1) ? $clog2(NoSlv) : 1;

  logic [IdxW-1:0] r_ptr, r_lidx;
  logic            r_lock;
  int              w_cand;

  // Walk from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    gnt_idx   = r_ptr;
    gnt_valid = 1'b0;
    w_cand    = 0;
    if (r_lock) begin
      gnt_idx   = r_lidx;
      gnt_valid = valid[r_lidx];
    end else begin
      for (int k = NoSlv - 1; k >= 0; k--) begin
        w_cand = int'(r_ptr) + k;
        if (w_cand >= NoSlv) w_cand = w_cand - NoSlv;
        if (valid[IdxW'(w_cand)]) begin
          gnt_idx   = IdxW'(w_cand);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr  <= '0;
      r_lock <= 1'b0;
      r_lidx <= '0;
    end else begin
      r_lock <= gnt_valid & ~ready;
      if (gnt_valid & ~ready) r_lidx <= gnt_idx;
      if (gnt_valid & ready)
        r_ptr <= (gnt_idx == IdxW'(NoSlv - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/xadac_arb.sv
// xadac_arb: NoSlv issuers sharing one xadac accelerator port.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   slv[]      issuer-facing ports
//   mst        accelerator-facing port
// Dec and exe requests are arbitrated independently. Responses return to the
// issuer recorded as the owner of the instruction id. The table is written on
// each dec_req handshake, and that write is visible in the same cycle.
module xadac_arb
  import xadac_pkg::*;
#(
  parameter int NoSlv = 2
) (
  input logic    clk,
  input logic    rstn,
  xadac_if.slv   slv [NoSlv],
  xadac_if.mst   mst
);
  localparam int IdxW = (NoSlv > 1) ? $clog2(NoSlv) : 1;

  DecReqT          w_dec_req [NoSlv];
  ExeReqT          w_exe_req [NoSlv];
  logic [NoSlv-1:0] w_dec_vld, w_exe_vld, w_dec_rsp_rdy, w_exe_rsp_rdy;
  logic [IdxW-1:0] w_dec_gnt, w_exe_gnt, w_dec_own, w_exe_own;
  logic            w_dec_gv, w_exe_gv, w_dec_hs;
  DecReqT          w_dec_req_m;
  logic [IdxW-1:0] r_own   [SbLen];
  logic [IdxW-1:0] w_own_d [SbLen];

  xadac_rr_arb #(.NoSlv(NoSlv)) u_dec_arb (
    .clk(clk), .rstn(rstn), .valid(w_dec_vld), .ready(mst.dec_req_ready),
    .gnt_idx(w_dec_gnt), .gnt_valid(w_dec_gv)
  );

  xadac_rr_arb #(.NoSlv(NoSlv)) u_exe_arb (
    .clk(clk), .rstn(rstn), .valid(w_exe_vld), .ready(mst.exe_req_ready),
    .gnt_idx(w_exe_gnt), .gnt_valid(w_exe_gv)
  );

  assign w_dec_req_m       = w_dec_gv ? w_dec_req[w_dec_gnt] : '0;
  assign w_dec_hs          = w_dec_gv & mst.dec_req_ready;
  assign mst.dec_req       = w_dec_req_m;
  assign mst.dec_req_valid = w_dec_gv;
  assign mst.exe_req       = w_exe_gv ? w_exe_req[w_exe_gnt] : '0;
  assign mst.exe_req_valid = w_exe_gv;

  // Owner lookup sees this cycle's write, so an accelerator that answers
  // in the same cycle as the dec_req handshake still routes correctly.
  always_comb begin
    w_own_d = r_own;
    if (w_dec_hs) w_own_d[w_dec_req_m.id] = w_dec_gnt;
  end

  assign w_dec_own         = w_own_d[mst.dec_rsp.id];
  assign w_exe_own         = w_own_d[mst.exe_rsp.id];
  assign mst.dec_rsp_ready = w_dec_rsp_rdy[w_dec_own];
  assign mst.exe_rsp_ready = w_exe_rsp_rdy[w_exe_own];

  for (genvar g = 0; g < NoSlv; g++) begin : g_slv
    localparam logic [IdxW-1:0] G = IdxW'(g);
    assign w_dec_req[g]     = slv[g].dec_req;
    assign w_dec_vld[g]     = slv[g].dec_req_valid;
    assign w_exe_req[g]     = slv[g].exe_req;
    assign w_exe_vld[g]     = slv[g].exe_req_valid;
    assign w_dec_rsp_rdy[g] = slv[g].dec_rsp_ready;
    assign w_exe_rsp_rdy[g] = slv[g].exe_rsp_ready;

    assign slv[g].dec_req_ready = w_dec_gv & (w_dec_gnt == G) & mst.dec_req_ready;
    assign slv[g].exe_req_ready = w_exe_gv & (w_exe_gnt == G) & mst.exe_req_ready;
    assign slv[g].dec_rsp_valid = (w_dec_own == G) & mst.dec_rsp_valid;
    assign slv[g].dec_rsp       = (w_dec_own == G) ? mst.dec_rsp : '0;
    assign slv[g].exe_rsp_valid = (w_exe_own == G) & mst.exe_rsp_valid;
    assign slv[g].exe_rsp       = (w_exe_own == G) ? mst.exe_rsp : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SbLen; i++) r_own[i] <= '0;
    end else if (w_dec_hs) begin
      r_own[w_dec_req_m.id] <= w_dec_gnt;
    end
  end
endmodule

// File: tb/tb_xadac_arb.sv
module tb_xadac_arb;
  import xadac_pkg::*;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  xadac_if mst_if ();
  xadac_if slv_if [NS] ();

  DecReqT        s_dec_req [NS];
  ExeReqT        s_exe_req [NS];
  logic [NS-1:0] s_dec_vld, s_exe_vld, s_dec_rsp_rdy, s_exe_rsp_rdy;
  logic [NS-1:0] o_dec_rdy, o_exe_rdy, o_dec_rsp_vld, o_exe_rsp_vld;
  DecRspT        o_dec_rsp [NS];
  ExeRspT        o_exe_rsp [NS];
  logic          m_dec_rdy, m_exe_rdy, m_dec_rsp_vld, m_exe_rsp_vld;
  DecRspT        m_dec_rsp;
  ExeRspT        m_exe_rsp;

  for (genvar g = 0; g < NS; g++) begin : g_map
    assign slv_if[g].dec_req       = s_dec_req[g];
    assign slv_if[g].dec_req_valid = s_dec_vld[g];
    assign slv_if[g].dec_rsp_ready = s_dec_rsp_rdy[g];
    assign slv_if[g].exe_req       = s_exe_req[g];
    assign slv_if[g].exe_req_valid = s_exe_vld[g];
    assign slv_if[g].exe_rsp_ready = s_exe_rsp_rdy[g];
    assign o_dec_rdy[g]     = slv_if[g].dec_req_ready;
    assign o_exe_rdy[g]     = slv_if[g].exe_req_ready;
    assign o_dec_rsp_vld[g] = slv_if[g].dec_rsp_valid;
    assign o_exe_rsp_vld[g] = slv_if[g].exe_rsp_valid;
    assign o_dec_rsp[g]     = slv_if[g].dec_rsp;
    assign o_exe_rsp[g]     = slv_if[g].exe_rsp;
  end

  assign mst_if.dec_req_ready = m_dec_rdy;
  assign mst_if.exe_req_ready = m_exe_rdy;
  assign mst_if.dec_rsp       = m_dec_rsp;
  assign mst_if.dec_rsp_valid = m_dec_rsp_vld;
  assign mst_if.exe_rsp       = m_exe_rsp;
  assign mst_if.exe_rsp_valid = m_exe_rsp_vld;

  xadac_arb #(.NoSlv(NS)) dut (.clk(clk), .rstn(rstn), .slv(slv_if), .mst(mst_if));

  int checks = 0;
  int errors = 0;

  // Reference model: next-to-serve position, pending unaccepted grant, id owners.
  int md_ptr, me_ptr, md_li, me_li;
  bit md_lk, me_lk;
  int own_m [SbLen];
  int dg, eg, hd, he;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // First requester in rotating order from ptr; a pending grant wins outright.
  function automatic int pick(input logic [NS-1:0] v, input int ptr, input bit lk, input int li);
    if (lk) return li;
    for (int k = 0; k < NS; k++) if (v[(ptr + k) % NS]) return (ptr + k) % NS;
    return -1;
  endfunction

  task automatic model_reset();
    md_ptr = 0; me_ptr = 0; md_lk = 0; me_lk = 0; md_li = 0; me_li = 0;
    for (int i = 0; i < SbLen; i++) own_m[i] = 0;
  endtask

  task automatic eval();
    int od [SbLen];
    int dt, et;
    logic [NS-1:0] e;
    #1;
    dg = pick(s_dec_vld, md_ptr, md_lk, md_li);
    eg = pick(s_exe_vld, me_ptr, me_lk, me_li);
    chk("dec_vld", 64'(mst_if.dec_req_valid), 64'(dg >= 0));
    chk("dec_req", 64'(mst_if.dec_req), (dg >= 0) ? 64'(s_dec_req[dg]) : 64'd0);
    e = '0; if (dg >= 0 && m_dec_rdy) e = NS'(1) << dg;
    chk("dec_rdy", 64'(o_dec_rdy), 64'(e));
    chk("exe_vld", 64'(mst_if.exe_req_valid), 64'(eg >= 0));
    chk("exe_req", 64'(mst_if.exe_req), (eg >= 0) ? 64'(s_exe_req[eg]) : 64'd0);
    e = '0; if (eg >= 0 && m_exe_rdy) e = NS'(1) << eg;
    chk("exe_rdy", 64'(o_exe_rdy), 64'(e));
    od = own_m;
    if (dg >= 0 && m_dec_rdy) od[s_dec_req[dg].id] = dg;
    dt = od[m_dec_rsp.id];
    et = od[m_exe_rsp.id];
    e = '0; if (m_dec_rsp_vld) e = NS'(1) << dt;
    chk("dec_rsp_vld", 64'(o_dec_rsp_vld), 64'(e));
    e = '0; if (m_exe_rsp_vld) e = NS'(1) << et;
    chk("exe_rsp_vld", 64'(o_exe_rsp_vld), 64'(e));
    for (int i = 0; i < NS; i++) begin
      chk("dec_rsp", 64'(o_dec_rsp[i]), (i == dt) ? 64'(m_dec_rsp) : 64'd0);
      chk("exe_rsp", 64'(o_exe_rsp[i]), (i == et) ? 64'(m_exe_rsp) : 64'd0);
    end
    chk("dec_rsp_rdy", 64'(mst_if.dec_rsp_ready), 64'(s_dec_rsp_rdy[dt]));
    chk("exe_rsp_rdy", 64'(mst_if.exe_rsp_ready), 64'(s_exe_rsp_rdy[et]));
  endtask

  task automatic adv();
    hd = -1; he = -1;
    @(posedge clk);
    if (dg >= 0) begin
      if (m_dec_rdy) begin
        own_m[s_dec_req[dg].id] = dg; md_ptr = (dg + 1) % NS; md_lk = 0; hd = dg;
      end else begin md_lk = 1; md_li = dg; end
    end else md_lk = 0;
    if (eg >= 0) begin
      if (m_exe_rdy) begin me_ptr = (eg + 1) % NS; me_lk = 0; he = eg; end
      else begin me_lk = 1; me_li = eg; end
    end else me_lk = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic set_dec(input int i, input int id);
    s_dec_vld[i] = 1'b1;
    s_dec_req[i].id = SbIdW'(id);
    s_dec_req[i].instr = $urandom;
  endtask

  initial begin
    s_dec_vld = '0; s_exe_vld = '0; s_dec_rsp_rdy = '0; s_exe_rsp_rdy = '0;
    for (int i = 0; i < NS; i++) begin s_dec_req[i] = '0; s_exe_req[i] = '0; end
    m_dec_rdy = 1'b1; m_exe_rdy = 1'b1; m_dec_rsp_vld = 1'b0; m_exe_rsp_vld = 1'b0;
    m_dec_rsp = '0; m_exe_rsp = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state: nothing requested, nothing granted.
    eval();
    chk("rst_dec_vld", 64'(mst_if.dec_req_valid), 64'd0);
    chk("rst_exe_vld", 64'(mst_if.exe_req_valid), 64'd0);
    adv();

    // Two simultaneous dec requests: slv0 first, slv1 next.
    set_dec(0, 1); set_dec(1, 5);
    eval();
    chk("tp_c0_rdy", 64'(o_dec_rdy), 64'b0001);
    chk("tp_c0_id", 64'(mst_if.dec_req.id), 64'd1);
    adv(); s_dec_vld[0] = 1'b0;
    eval();
    chk("tp_c1_rdy", 64'(o_dec_rdy), 64'b0010);
    chk("tp_c1_id", 64'(mst_if.dec_req.id), 64'd5);
    adv(); s_dec_vld[1] = 1'b0;

    // Lock: slv1 held through three not-ready cycles despite slv0 arriving.
    m_dec_rdy = 1'b0; set_dec(1, 6);
    eval(); chk("lk_c0_id", 64'(mst_if.dec_req.id), 64'd6); adv();
    set_dec(0, 0);
    eval(); chk("lk_c1_id", 64'(mst_if.dec_req.id), 64'd6); adv();
    eval(); chk("lk_c2_id", 64'(mst_if.dec_req.id), 64'd6); adv();
    m_dec_rdy = 1'b1;
    eval(); chk("lk_c3_rdy", 64'(o_dec_rdy), 64'b0010); adv();
    s_dec_vld[1] = 1'b0;
    eval(); chk("lk_c4_rdy", 64'(o_dec_rdy), 64'b0001); adv();
    s_dec_vld[0] = 1'b0;

    // Response routing by id owner.
    m_dec_rsp_vld = 1'b1; m_dec_rsp = '{id: 3'd5, accept: 1'b1, rd: 5'd9};
    s_dec_rsp_rdy = 4'b0010;
    eval();
    chk("rt_dec_vld", 64'(o_dec_rsp_vld), 64'b0010);
    chk("rt_dec_rdy", 64'(mst_if.dec_rsp_ready), 64'd1);
    adv();
    m_dec_rsp_vld = 1'b0;
    m_exe_rsp_vld = 1'b1; m_exe_rsp = '{id: 3'd1, rd_data: 32'hCAFE_0001};
    s_exe_rsp_rdy = 4'b1110;
    eval();
    chk("rt_exe_vld", 64'(o_exe_rsp_vld), 64'b0001);
    chk("rt_exe_rdy", 64'(mst_if.exe_rsp_ready), 64'd0);
    adv();
    m_exe_rsp_vld = 1'b0;

    // Same-cycle bypass: dec_rsp for the id being handed over this cycle.
    set_dec(1, 7);
    m_dec_rsp_vld = 1'b1; m_dec_rsp = '{id: 3'd7, accept: 1'b1, rd: 5'd3};
    eval();
    chk("byp_vld", 64'(o_dec_rsp_vld), 64'b0010);
    adv();
    s_dec_vld[1] = 1'b0; m_dec_rsp_vld = 1'b0;

    // Fairness on exe: everyone requesting, ready every cycle.
    s_exe_vld = '1;
    for (int i = 0; i < NS; i++) s_exe_req[i] = '{id: SbIdW'(i), rs1: $urandom};
    for (int c = 0; c < 6; c++) begin
      eval();
      chk("fair_rdy", 64'(o_exe_rdy), 64'(NS'(1) << (c % NS)));
      adv();
    end
    do_reset();
    eval();
    chk("fair_rst_rdy", 64'(o_exe_rdy), 64'b0001);
    adv();
    s_exe_vld = '0;

    // Randomized traffic; requesters hold valid until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!s_dec_vld[i] && $urandom_range(0, 1) == 1) set_dec(i, $urandom_range(0, SbLen - 1));
        if (!s_exe_vld[i] && $urandom_range(0, 1) == 1) begin
          s_exe_vld[i] = 1'b1;
          s_exe_req[i] = '{id: SbIdW'($urandom_range(0, SbLen - 1)), rs1: $urandom};
        end
      end
      s_dec_rsp_rdy = NS'($urandom);
      s_exe_rsp_rdy = NS'($urandom);
      m_dec_rdy = 1'($urandom_range(0, 1));
      m_exe_rdy = 1'($urandom_range(0, 1));
      m_dec_rsp_vld = 1'($urandom_range(0, 1));
      m_exe_rsp_vld = 1'($urandom_range(0, 1));
      m_dec_rsp = '{id: SbIdW'($urandom_range(0, SbLen - 1)), accept: 1'($urandom), rd: 5'($urandom)};
      m_exe_rsp = '{id: SbIdW'($urandom_range(0, SbLen - 1)), rd_data: $urandom};
      eval();
      adv();
      if (hd >= 0) s_dec_vld[hd] = 1'b0;
      if (he >= 0) s_exe_vld[he] = 1'b0;
      if (c == 200) begin
        s_dec_vld = '0; s_exe_vld = '0;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xadac_arb.md
# xadac_arb

Round-robin N-to-1 arbiter that lets several xadac issuers (CVA6 instances or issue ports) share one xadac accelerator port. Decode and execute requests are arbitrated independently, with grant locking so an issued request stays stable until it is accepted. Decode and execute responses are routed back to the issuer that owns the instruction id, using an id-owner table. It sits between the issuing cores and the xadac decode mux, or directly in front of a single accelerator.

## Interface
- `NoSlv`, default 2: number of issuer ports; ≥2.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; one clock, asynchronous, active-low.
- `slv`  xadac_if.slv  [NoSlv]  issuer-facing ports.
- `mst`  xadac_if.mst  1  accelerator-facing port.

## Operation
- Fields used: `dec_req.id`, `dec_rsp.id`, `exe_req.id`, `exe_rsp.id`, all `SbLen`-indexed.
- Issuers use disjoint id sets; this is a system-level rule and is not checked.
- Dec req channel:
  - Round-robin arbiter over `slv[i].dec_req_valid`.
  - The winner's `dec_req`/valid drive `mst`.
  - `mst.dec_req_ready` returns only to the winner; all others see ready=0.
- Exe req channel: independent round-robin arbiter, identical rules, own pointer and lock.
- Lock: if `mst.*_req_valid`=1 and ready=0 at a clock edge, that grant is held next cycle regardless of other requesters. The lock clears on handshake.
- Pointer: on handshake with winner w, priority pointer becomes (w+1) mod NoSlv. With no handshake the pointer is unchanged.
- Owner table `own[SbLen]`, each entry `$clog2(NoSlv)` bits:
  - On a dec_req handshake, `own[dec_req.id]` ← winner index.
- Dec rsp routing:
  - `slv[own_d[mst.dec_rsp.id]]` gets `mst.dec_rsp`/valid.
  - `mst.dec_rsp_ready` comes from that slv.
  - Other slv see rsp='0, valid=0.
- Exe rsp routing: same rule, keyed on `mst.exe_rsp.id`.
- Bypass: `own_d` is the table including the current cycle's write, so a dec_rsp for an id written in the same cycle routes correctly.
- Idle outputs: every unselected output is '0; `mst` req valid=0 when no slv is requesting.

## Timing
- Fully combinational forward and return paths: zero-cycle latency, no added bubbles. Back-to-back handshakes every cycle are possible on all four channels simultaneously.
- Registers: two RR pointers, two lock flags, two locked-winner indices, owner table.
- Reset values: pointers 0, locks 0, owner table all 0.
- Outputs have no reset value of their own; they follow inputs combinationally.
- Reset mid-operation: locks and pointers clear asynchronously. The next grant starts from slv 0 priority; in-flight table contents are lost.
- Simultaneous events:
  - dec_req from slv0 and slv1 in the same cycle with pointer 0 → slv0 granted, then slv1 next cycle.
  - A locked grant overrides a higher-priority newcomer.
- Stability: a slv that drops valid while locked is a protocol violation (undefined). The block needs no special handling.

## Structure
- `SbLen`, `DecReqT`, `DecRspT`, `ExeReqT`, `ExeRspT` come from `xadac_pkg`; add no new package types.
- One sub-module: `xadac_rr_arb`, a generic NoSlv-way round-robin with lock.
  - Inputs: `valid[NoSlv]`, `ready`.
  - Outputs: `gnt_idx`, `gnt_valid`.
  - Instantiate twice (dec req, exe req).

## Test plan
- Reset, then slv0 and slv1 assert dec_req (ids 1, 5) with mst ready=1:
  - cycle 0 grants slv0 (id 1), cycle 1 grants slv1 (id 5).
  - `own[1]`=0, `own[5]`=1.
- Lock: slv1 dec_req with mst ready=0 for 3 cycles, slv0 raises valid in cycle 1:
  - slv1 stays granted until ready=1; slv0 is served the next cycle.
- Response routing: after the ids above, mst returns dec_rsp id 5 then exe_rsp id 1:
  - delivered only to slv1 then slv0; other ports see valid=0.
  - `mst.*_rsp_ready` mirrors the target slv's ready.
- Same-cycle bypass: accelerator answers dec_rsp id 7 combinationally in the dec_req handshake cycle from slv1 → routed to slv1.
- Fairness: all NoSlv=4 ports hold exe_req_valid continuously, mst ready=1 → grant order 0,1,2,3,0… with no port skipped. Includes assert rstn low mid-sequence → next grant is slv0.
